// File: rtl/hmem_arbiter.sv
// rtl/hmem_arbiter.sv - round-robin burst arbiter sharing one memory port between two cache controllers
module hmem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int BEATS  = 4,
  parameter int OP_W   = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              r0_req_valid,
  input  logic [OP_W-1:0]   r0_req_operation,
  input  logic [ADDR_W-1:0] r0_req_address,
  input  logic [DATA_W-1:0] r0_req_store_data,
  output logic              r0_req_fulfilled,
  output logic [DATA_W-1:0] r0_req_loaded_data,
  input  logic              r1_req_valid,
  input  logic [OP_W-1:0]   r1_req_operation,
  input  logic [ADDR_W-1:0] r1_req_address,
  input  logic [DATA_W-1:0] r1_req_store_data,
  output logic              r1_req_fulfilled,
  output logic [DATA_W-1:0] r1_req_loaded_data,
  output logic              m_req_valid,
  output logic [OP_W-1:0]   m_req_operation,
  output logic [ADDR_W-1:0] m_req_address,
  output logic [DATA_W-1:0] m_req_store_data,
  input  logic              m_req_fulfilled,
  input  logic [DATA_W-1:0] m_req_loaded_data,
  output logic              grant_owner,
  output logic              busy
);

  localparam int              CNT_W     = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);
  localparam logic [OP_W-1:0]  OP_LOAD   = '0;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_GRANT0 = 2'd1;
  localparam logic [1:0] ST_GRANT1 = 2'd2;

  logic [1:0]       r_state;
  logic [1:0]       w_next_state;
  logic [CNT_W-1:0] r_beat_count;
  logic             r_last_winner;
  logic             r_grant_owner;
  logic             w_grant_valid;
  logic             w_grant_idx;
  logic             w_own_valid;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= ST_IDLE;
      r_beat_count  <= '0;
      r_last_winner <= 1'b1;
      r_grant_owner <= 1'b0;
    end else begin
      r_state <= w_next_state;
      case (r_state)
        ST_IDLE: begin
          if (w_grant_valid) begin
            r_beat_count  <= LAST_BEAT;
            r_last_winner <= w_grant_idx;
            r_grant_owner <= w_grant_idx;
          end
        end
        ST_GRANT0, ST_GRANT1: begin
          if (m_req_fulfilled) begin
            if (r_beat_count != '0) r_beat_count <= r_beat_count - 1'b1;
          end else if (!w_own_valid) begin
            r_beat_count <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  // Ties go to whichever requester did not win last, so a busy requester cannot starve the other.
  always_comb begin
    w_next_state  = r_state;
    w_grant_valid = 1'b0;
    w_grant_idx   = 1'b0;
    w_own_valid   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (r0_req_valid && r1_req_valid) begin
          w_grant_valid = 1'b1;
          w_grant_idx   = ~r_last_winner;
        end else if (r0_req_valid) begin
          w_grant_valid = 1'b1;
          w_grant_idx   = 1'b0;
        end else if (r1_req_valid) begin
          w_grant_valid = 1'b1;
          w_grant_idx   = 1'b1;
        end
        if (w_grant_valid) w_next_state = w_grant_idx ? ST_GRANT1 : ST_GRANT0;
      end
      ST_GRANT0, ST_GRANT1: begin
        w_own_valid = (r_state == ST_GRANT0) ? r0_req_valid : r1_req_valid;
        if (m_req_fulfilled && (r_beat_count == '0)) w_next_state = ST_IDLE;
        else if (!m_req_fulfilled && !w_own_valid)   w_next_state = ST_IDLE;
      end
      default: w_next_state = 'x;
    endcase
  end

  always_comb begin
    m_req_valid      = 1'b0;
    m_req_operation  = OP_LOAD;
    m_req_address    = '0;
    m_req_store_data = '0;
    r0_req_fulfilled = 1'b0;
    r1_req_fulfilled = 1'b0;
    busy             = 1'b0;
    case (r_state)
      ST_IDLE: ;
      ST_GRANT0: begin
        m_req_valid      = r0_req_valid;
        m_req_operation  = r0_req_operation;
        m_req_address    = r0_req_address;
        m_req_store_data = r0_req_store_data;
        r0_req_fulfilled = m_req_fulfilled;
        busy             = 1'b1;
      end
      ST_GRANT1: begin
        m_req_valid      = r1_req_valid;
        m_req_operation  = r1_req_operation;
        m_req_address    = r1_req_address;
        m_req_store_data = r1_req_store_data;
        r1_req_fulfilled = m_req_fulfilled;
        busy             = 1'b1;
      end
      default: begin
        m_req_valid      = 'x;
        m_req_operation  = 'x;
        m_req_address    = 'x;
        m_req_store_data = 'x;
        r0_req_fulfilled = 'x;
        r1_req_fulfilled = 'x;
        busy             = 'x;
      end
    endcase
  end

  assign r0_req_loaded_data = m_req_loaded_data;
  assign r1_req_loaded_data = m_req_loaded_data;
  assign grant_owner        = r_grant_owner;

endmodule
